mtimer: RTL and testbench
=========================

# mtimer

Machine-mode timer that produces the `tm_interupt` level consumed by the core's interrupt/CSR logic. It holds a 64-bit free-running `mtime` counter, advanced by a programmable-enable prescaled tick, and a 64-bit `mtimecmp` compare register. Both are exposed to the load/store unit as word-addressed memory-mapped registers. The block asserts `tm_interupt` while `mtime >= mtimecmp`, and software clears it by rewriting `mtimecmp`.

## Interface
Parameters:
- `PRESCALE`, default 1: clock cycles per `mtime` increment. Legal range is 1..65535.

Ports:
- `clk`, input, 1: single clock. All state updates on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `sel`, input, 1: the data-memory decoder has selected this block.
- `wr_en`, input, 1: store strobe. Qualified by `sel`.
- `rd_en`, input, 1: load strobe. Qualified by `sel`.
- `addr`, input, 5: byte offset. Only `addr[4:2]` is decoded; `addr[1:0]` is ignored.
- `wdata`, input, 32: store data. Word writes only.
- `rdata`, output, 32: load data.
- `tm_interupt`, output, 1: machine timer interrupt request (level).

## Operation
- Register map (`addr[4:2]`):
  - 0: `mtime[31:0]`
  - 1: `mtime[63:32]`
  - 2: `mtimecmp[31:0]`
  - 3: `mtimecmp[63:32]`
  - 4: `ctrl`. Bit 0 is `en`; bits 31:1 read 0 and ignore writes.
  - 5–7: reserved. Reads return 0; writes are ignored.
- Reset values:
  - `mtime` = 0
  - `mtimecmp` = 64'hFFFF_FFFF_FFFF_FFFF
  - `en` = 0
  - prescaler count = 0
  - `tm_interupt` = 0
- Prescaler:
  - While `en` = 1, `pcnt` counts 0..PRESCALE-1. `tick` = (`pcnt` == PRESCALE-1) & `en`; `pcnt` wraps to 0 on `tick`.
  - With PRESCALE = 1, `tick` asserts every cycle that `en` is 1.
  - While `en` = 0, `pcnt` holds its value and `tick` = 0.
- Counter:
  - On `tick`, `mtime` <= `mtime` + 1, a 64-bit unsigned increment.
  - 64'hFFFF_FFFF_FFFF_FFFF wraps to 0 with no flag.
- Writes when `sel & wr_en`:
  - The addressed word is replaced at the next edge.
  - The other word of the same 64-bit register is unaffected.
- Simultaneous write and tick:
  - Write to `mtime` low word: low word = `wdata`; high word holds, with no carry.
  - Write to `mtime` high word: high word = `wdata`; low word = low + 1, and any carry out of the low word is discarded.
  - Writes to `mtimecmp` or `ctrl` do not interact with the tick.
- Reads:
  - `rdata` = addressed register when `sel & rd_en`, otherwise 0. The read is combinational.
  - A read in the same cycle as a write returns the pre-write value.
- Compare:
  - The comparison is unsigned and 64 bits wide.
  - `tm_interupt` <= (`mtime` >= `mtimecmp`), using the register values of the current cycle.
  - `tm_interupt` is independent of `en`.
  - The block has no other pending state; the interrupt clears only when the compare condition goes false.
- `sel` with both `wr_en` and `rd_en` high: the write happens and `rdata` still returns the pre-write value.

## Timing
- Read latency is 0 cycles, so the block fits the core's single-cycle load path.
- Write latency is 1 edge.
- From a `mtime` or `mtimecmp` update at edge N to the `tm_interupt` change at edge N+1 is 1 cycle.
  - Example: a write to `mtimecmp` that makes `mtime` < `mtimecmp` at edge N deasserts `tm_interupt` after edge N+1.
- Updating a 64-bit register takes two word writes. Between them, `tm_interupt` may glitch for one or more cycles.
  - Software writes `mtimecmp[63:32]` = all-ones first, then the low word, then the high word.
  - The block does not guard against the glitch.
- Reset asserted in any cycle, including mid-update, forces all reset values at that edge. `rdata` is 0 while `rst` is high.
- Clearing `en` freezes `mtime` and `pcnt` starting at the next edge. Setting `en` resumes counting from the held `pcnt`.

## Structure
- Shared package `mtimer_pkg`:
  - Offset constants `MTIME_LO`=3'd0, `MTIME_HI`=3'd1, `MTIMECMP_LO`=3'd2, `MTIMECMP_HI`=3'd3, `MTIMER_CTRL`=3'd4.
  - `MTIMECMP_RST` = 64'hFFFF_FFFF_FFFF_FFFF.
  - `CTRL_EN_BIT` = 0.
- Sub-module `tick_gen`:
  - Parameterised by PRESCALE.
  - Inputs `clk`, `rst`, `en`; output `tick`.
  - Contains the prescaler counter only.
- The top level holds the register file, write decode, the read mux, the 64-bit increment and the comparator.

## Test plan
- Reset, then read all 8 offsets → 0, 0, FFFF_FFFF, FFFF_FFFF, 0, 0, 0, 0. `tm_interupt` = 0.
- PRESCALE=4; write `ctrl`=1, then wait 40 cycles → `mtime` low reads 10. Clear `en`, wait 20 cycles → still 10.
- PRESCALE=1; `mtimecmp`=5, `en`=1 → `tm_interupt` rises exactly 1 cycle after `mtime` reads 5. Write `mtimecmp` low word = 100 → `tm_interupt` falls 1 cycle after the write edge.
- Write `mtime`=64'h0000_0000_FFFF_FFFF with `en`=1, PRESCALE=1 → after 1 tick the reads are low 0, high 1. Write all-ones to both words → `mtime` wraps to 0.
- Write `mtime` low word in a tick cycle → low word = `wdata`, high word unchanged. Write `mtime` high word in a tick cycle → low word incremented, high word = `wdata`.
- Assert `rst` mid-count with `tm_interupt`=1 → all registers return to reset values and `tm_interupt` = 0 after the edge. Access to offset 0x14 → reads 0 and the write has no effect.

Source files
------------

// File: rtl/mtimer_pkg.sv
// Shared register offsets and reset constants for the machine-mode timer.
package mtimer_pkg;

  typedef enum logic [2:0] {
    MTIME_LO    = 3'd0,
    MTIME_HI    = 3'd1,
    MTIMECMP_LO = 3'd2,
    MTIMECMP_HI = 3'd3,
    MTIMER_CTRL = 3'd4
  } reg_off_e;

  localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam int unsigned CTRL_EN_BIT  = 0;

endpackage

// File: rtl/mtimer_tick_gen.sv
// Prescaler: emits a one-cycle tick every PRESCALE enabled cycles.
module tick_gen #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam logic [15:0] LAST = 16'(PRESCALE - 1);

  logic [15:0] pcnt_q;

  assign tick = en && (pcnt_q == LAST);

  // Count is held, not cleared, while disabled so counting resumes mid-period.
  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt_q <= '0;
    end else if (tick) begin
      pcnt_q <= '0;
    end else if (en) begin
      pcnt_q <= pcnt_q + 16'd1;
    end
  end

endmodule

// File: rtl/mtimer.sv
// Machine timer: 64-bit mtime/mtimecmp with word-mapped access and a level interrupt.
module mtimer
  import mtimer_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [4:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        tm_interupt
);

  logic [63:0] mtime_q, mtime_d, mtime_inc;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic        en_q, en_d;
  logic        irq_q;
  logic        tick;
  logic        wr, rd;
  reg_off_e    off;
  logic        unused_addr;

  assign unused_addr = ^addr[1:0];
  assign off         = reg_off_e'(addr[4:2]);
  assign wr          = sel & wr_en;
  assign rd          = sel & rd_en;

  tick_gen #(.PRESCALE(PRESCALE)) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (en_q),
    .tick (tick)
  );

  // A high-word write keeps the ticked low word but drops its carry;
  // a low-word write replaces the low word and leaves the high word alone.
  always_comb begin
    mtime_inc  = mtime_q + 64'(tick);
    mtime_d    = mtime_inc;
    mtimecmp_d = mtimecmp_q;
    en_d       = en_q;
    if (wr) begin
      case (off)
        MTIME_LO:    mtime_d = {mtime_q[63:32], wdata};
        MTIME_HI:    mtime_d = {wdata, mtime_inc[31:0]};
        MTIMECMP_LO: mtimecmp_d[31:0] = wdata;
        MTIMECMP_HI: mtimecmp_d[63:32] = wdata;
        MTIMER_CTRL: en_d = wdata[CTRL_EN_BIT];
        default:     ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mtime_q    <= '0;
      mtimecmp_q <= MTIMECMP_RST;
      en_q       <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      en_q       <= en_d;
      irq_q      <= (mtime_q >= mtimecmp_q);
    end
  end

  always_comb begin
    rdata = '0;
    if (rd && !rst) begin
      case (off)
        MTIME_LO:    rdata = mtime_q[31:0];
        MTIME_HI:    rdata = mtime_q[63:32];
        MTIMECMP_LO: rdata = mtimecmp_q[31:0];
        MTIMECMP_HI: rdata = mtimecmp_q[63:32];
        MTIMER_CTRL: rdata = {31'd0, en_q};
        default:     rdata = '0;
      endcase
    end
  end

  assign tm_interupt = irq_q;

endmodule

// File: tb/tb_mtimer.sv
// Self-checking bench: two timers (PRESCALE 1 and 4) share one bus, checked against an arithmetic model.
module tb_mtimer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rst_req = 1'b1;
  logic        sel = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
  logic [4:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata1, rdata4;
  logic        irq1, irq4;
  logic [31:0] rdv [2];
  logic        irqv [2];

  int checks = 0;
  int failures = 0;

  assign rdv[0]  = rdata1;
  assign rdv[1]  = rdata4;
  assign irqv[0] = irq1;
  assign irqv[1] = irq4;

  always #5 clk = ~clk;

  mtimer #(.PRESCALE(1)) dut1 (
    .clk(clk), .rst(rst), .sel(sel), .wr_en(wr_en), .rd_en(rd_en),
    .addr(addr), .wdata(wdata), .rdata(rdata1), .tm_interupt(irq1)
  );

  mtimer #(.PRESCALE(4)) dut4 (
    .clk(clk), .rst(rst), .sel(sel), .wr_en(wr_en), .rd_en(rd_en),
    .addr(addr), .wdata(wdata), .rdata(rdata4), .tm_interupt(irq4)
  );

  // Reference model: time as a 64-bit number, ticks derived from the count of enabled cycles.
  longint unsigned m_time [2];
  longint unsigned m_cmp  [2];
  bit              m_en   [2];
  bit              m_irq  [2];
  int unsigned     m_ecnt [2];

  function automatic int unsigned ps(input int k);
    return (k == 0) ? 1 : 4;
  endfunction

  task automatic m_reset();
    for (int k = 0; k < 2; k++) begin
      m_time[k] = 0;
      m_cmp[k]  = 64'hFFFF_FFFF_FFFF_FFFF;
      m_en[k]   = 1'b0;
      m_irq[k]  = 1'b0;
      m_ecnt[k] = 0;
    end
  endtask

  task automatic m_step();
    bit t;
    longint unsigned nt;
    if (rst) begin
      m_reset();
    end else begin
      for (int k = 0; k < 2; k++) begin
        t = m_en[k] && ((m_ecnt[k] % ps(k)) == ps(k) - 1);
        nt = m_time[k] + (t ? 64'd1 : 64'd0);
        m_irq[k] = (m_time[k] >= m_cmp[k]);
        if (m_en[k]) m_ecnt[k]++;
        if (sel && wr_en) begin
          case (addr[4:2])
            3'd0: nt = {m_time[k][63:32], wdata};
            3'd1: nt = {wdata, nt[31:0]};
            3'd2: m_cmp[k][31:0] = wdata;
            3'd3: m_cmp[k][63:32] = wdata;
            3'd4: m_en[k] = wdata[0];
            default: ;
          endcase
        end
        m_time[k] = nt;
      end
    end
  endtask

  function automatic logic [31:0] m_rd(input int k);
    if (rst || !(sel && rd_en)) return 32'd0;
    case (addr[4:2])
      3'd0: return m_time[k][31:0];
      3'd1: return m_time[k][63:32];
      3'd2: return m_cmp[k][31:0];
      3'd3: return m_cmp[k][63:32];
      3'd4: return {31'd0, m_en[k]};
      default: return 32'd0;
    endcase
  endfunction

  task automatic setb(input logic s, input logic w, input logic r,
                      input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    rst = rst_req; sel = s; wr_en = w; rd_en = r; addr = a; wdata = d;
    #1;
  endtask

  task automatic edge_step();
    @(posedge clk);
    m_step();
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    setb(1, 1, 0, a, d);
    edge_step();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      setb(0, 0, 0, 5'd0, 32'd0);
      edge_step();
    end
  endtask

  task automatic do_reset();
    rst_req = 1'b1;
    setb(0, 0, 0, 5'd0, 32'd0);
    edge_step();
    rst_req = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] exp_rst [8];
    exp_rst = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 32'd0};
    rst_req = 1'b1;
    setb(1, 0, 1, 5'd0, 32'd0);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (rdv[k] !== 32'd0) begin
        failures++;
        $display("FAIL rdata_in_reset dut%0d got %h exp 0", k, rdv[k]);
      end
    end
    edge_step();
    rst_req = 1'b0;
    for (int a = 0; a < 8; a++) begin
      setb(1, 0, 1, 5'(a * 4), 32'd0);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (rdv[k] !== exp_rst[a] || irqv[k] !== 1'b0) begin
          failures++;
          $display("FAIL reset_state dut%0d off%0d got %h/%b exp %h/0", k, a, rdv[k], irqv[k], exp_rst[a]);
        end
      end
      edge_step();
    end
  endtask

  task automatic test_prescale();
    do_reset();
    wr(5'd16, 32'd1);
    idle(40);
    setb(1, 0, 1, 5'd0, 32'd0);
    checks++;
    if (rdv[1] !== 32'd10) begin
      failures++;
      $display("FAIL prescale_count got %0d exp 10", rdv[1]);
    end
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (rdv[k] !== m_rd(k)) begin
        failures++;
        $display("FAIL prescale_model dut%0d got %h exp %h", k, rdv[k], m_rd(k));
      end
    end
    edge_step();
    wr(5'd16, 32'd0);
    idle(20);
    setb(1, 0, 1, 5'd0, 32'd0);
    checks++;
    if (rdv[1] !== 32'd10) begin
      failures++;
      $display("FAIL prescale_frozen got %0d exp 10", rdv[1]);
    end
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (rdv[k] !== m_rd(k)) begin
        failures++;
        $display("FAIL frozen_model dut%0d got %h exp %h", k, rdv[k], m_rd(k));
      end
    end
    edge_step();
  endtask

  task automatic test_compare();
    int found;
    found = -1;
    do_reset();
    wr(5'd12, 32'd0);
    wr(5'd8, 32'd5);
    wr(5'd16, 32'd1);
    for (int i = 0; i < 20 && found < 0; i++) begin
      setb(1, 0, 1, 5'd0, 32'd0);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (irqv[k] !== m_irq[k]) begin
          failures++;
          $display("FAIL cmp_irq_model dut%0d got %b exp %b", k, irqv[k], m_irq[k]);
        end
      end
      if (rdv[0] === 32'd5) begin
        found = i;
        checks++;
        if (irqv[0] !== 1'b0) begin
          failures++;
          $display("FAIL irq_early got %b exp 0", irqv[0]);
        end
      end
      edge_step();
    end
    checks++;
    if (found < 0) begin
      failures++;
      $display("FAIL mtime_reach_5 got timeout exp value 5 within 20 cycles");
    end
    setb(0, 0, 0, 5'd0, 32'd0);
    checks++;
    if (irqv[0] !== 1'b1) begin
      failures++;
      $display("FAIL irq_rise got %b exp 1", irqv[0]);
    end
    edge_step();
    wr(5'd8, 32'd100);
    for (int c = 0; c < 2; c++) begin
      setb(0, 0, 0, 5'd0, 32'd0);
      checks++;
      if (irqv[0] !== (c == 0)) begin
        failures++;
        $display("FAIL irq_fall_c%0d got %b exp %b", c, irqv[0], (c == 0));
      end
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (irqv[k] !== m_irq[k]) begin
          failures++;
          $display("FAIL fall_irq_model dut%0d got %b exp %b", k, irqv[k], m_irq[k]);
        end
      end
      edge_step();
    end
  endtask

  task automatic rd_expect(input string name, input logic [4:0] a, input logic [31:0] exp0);
    setb(1, 0, 1, a, 32'd0);
    checks++;
    if (rdv[0] !== exp0) begin
      failures++;
      $display("FAIL %s got %h exp %h", name, rdv[0], exp0);
    end
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (rdv[k] !== m_rd(k)) begin
        failures++;
        $display("FAIL %s_model dut%0d got %h exp %h", name, k, rdv[k], m_rd(k));
      end
    end
    edge_step();
  endtask

  task automatic test_wrap();
    do_reset();
    wr(5'd0, 32'hFFFF_FFFF);
    wr(5'd4, 32'd0);
    wr(5'd16, 32'd1);
    idle(1);
    rd_expect("carry_lo", 5'd0, 32'd0);
    rd_expect("carry_hi", 5'd4, 32'd1);
    wr(5'd16, 32'd0);
    wr(5'd0, 32'hFFFF_FFFF);
    wr(5'd4, 32'hFFFF_FFFF);
    wr(5'd16, 32'd1);
    idle(1);
    rd_expect("wrap_lo", 5'd0, 32'd0);
    rd_expect("wrap_hi", 5'd4, 32'd0);
  endtask

  task automatic test_tick_collision();
    do_reset();
    wr(5'd4, 32'd7);
    wr(5'd0, 32'hFFFF_FFFE);
    wr(5'd16, 32'd1);
    wr(5'd0, 32'hFFFF_FFFF);
    rd_expect("lo_wr_hi_hold", 5'd4, 32'd7);
    wr(5'd4, 32'h0000_ABCD);
    rd_expect("hi_wr_lo_inc", 5'd0, 32'd1);
    rd_expect("hi_wr_hi", 5'd4, 32'h0000_ABCD);
    wr(5'd16, 32'd0);
    wr(5'd0, 32'hFFFF_FFFF);
    wr(5'd16, 32'd1);
    wr(5'd4, 32'h55);
    rd_expect("hi_wr_no_carry", 5'd4, 32'h55);
  endtask

  task automatic test_reset_mid();
    do_reset();
    wr(5'd12, 32'd0);
    wr(5'd8, 32'd0);
    wr(5'd16, 32'd1);
    idle(3);
    setb(0, 0, 0, 5'd0, 32'd0);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (irqv[k] !== 1'b1) begin
        failures++;
        $display("FAIL irq_before_rst dut%0d got %b exp 1", k, irqv[k]);
      end
    end
    edge_step();
    rst_req = 1'b1;
    setb(1, 0, 1, 5'd12, 32'd0);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (rdv[k] !== 32'd0) begin
        failures++;
        $display("FAIL rdata_mid_rst dut%0d got %h exp 0", k, rdv[k]);
      end
    end
    edge_step();
    rst_req = 1'b0;
    setb(0, 0, 0, 5'd0, 32'd0);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (irqv[k] !== 1'b0) begin
        failures++;
        $display("FAIL irq_after_rst dut%0d got %b exp 0", k, irqv[k]);
      end
    end
    edge_step();
    rd_expect("rst_mtime_lo", 5'd0, 32'd0);
    rd_expect("rst_cmp_lo", 5'd8, 32'hFFFF_FFFF);
    rd_expect("rst_cmp_hi", 5'd12, 32'hFFFF_FFFF);
    rd_expect("rst_ctrl", 5'd16, 32'd0);
  endtask

  task automatic test_reserved();
    do_reset();
    wr(5'd20, 32'hFFFF_FFFF);
    wr(5'd30, 32'hFFFF_FFFF);
    rd_expect("resv_14", 5'd20, 32'd0);
    rd_expect("resv_mtime_lo", 5'd0, 32'd0);
    rd_expect("resv_mtime_hi", 5'd4, 32'd0);
    rd_expect("resv_cmp_lo", 5'd10, 32'hFFFF_FFFF);
    rd_expect("resv_cmp_hi", 5'd15, 32'hFFFF_FFFF);
    rd_expect("resv_ctrl", 5'd17, 32'd0);
  endtask

  task automatic test_random();
    logic [2:0]  off;
    logic [31:0] d;
    do_reset();
    for (int i = 0; i < 500; i++) begin
      off = 3'($urandom_range(0, 7));
      d = $urandom;
      if ((off == 3'd2 || off == 3'd3 || off == 3'd1) && ($urandom % 4 != 0))
        d = (off == 3'd2) ? $urandom_range(0, 60) : $urandom_range(0, 1);
      rst_req = ($urandom % 150 == 0);
      setb(($urandom % 4) != 0, $urandom % 3 == 0, $urandom % 2 == 0, {off, 2'($urandom)}, d);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (rdv[k] !== m_rd(k) || irqv[k] !== m_irq[k]) begin
          failures++;
          $display("FAIL random_c%0d dut%0d got %h/%b exp %h/%b", i, k, rdv[k], irqv[k], m_rd(k), m_irq[k]);
        end
      end
      edge_step();
    end
    rst_req = 1'b0;
  endtask

  initial begin
    m_reset();
    test_reset();
    test_prescale();
    test_compare();
    test_wrap();
    test_tick_collision();
    test_reset_mid();
    test_reserved();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
